rca_seq_ctrl: RTL and testbench

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

---
 rtl/rca_seq_pkg.sv | 13 +
 rtl/rca.sv | 30 +++
 rtl/rca_seq_ctrl.sv | 103 ++++++++++
 tb/tb_rca_seq_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared state encoding and default sizing for the sequential rca controller
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N     = 8;
  localparam int DEF_WORDS = 4;

endpackage

// File: rtl/rca.sv
// rtl/rca.sv - N-bit combinational ripple-carry adder shared by the chunk sequencer
module rca #(
  parameter int N = 8
) (
  input  logic         CLOCK_50,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  // The clock is carried on the port for drop-in compatibility; the adder itself is purely combinational.
  logic unused_clk;
  assign unused_clk = CLOCK_50;

  logic [N:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int i = 0; i < N; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end
    Cout = c[N];
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - W-bit add/subtract built from one N-bit rca stepped over WORDS chunks
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WORDS = DEF_WORDS
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] op_a,
  input  logic [N*WORDS-1:0] op_b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy
);

  localparam int W  = N * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    sum_r;
  logic            carry_r;
  logic            sa_r;
  logic            sb_r;
  logic            ovf_r;
  logic [KW-1:0]   k;
  logic [BW-1:0]   base;
  logic [N-1:0]    s_chunk;
  logic            c_chunk;

  assign base = BW'(k) * BW'(N);

  rca #(.N(N)) u_rca (
    .CLOCK_50 (CLOCK_50),
    .A        (a_r[base +: N]),
    .B        (b_r[base +: N]),
    .Cin      (carry_r),
    .S        (s_chunk),
    .Cout     (c_chunk)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      ovf_r   <= 1'b0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is folded into the operands so CALC only ever adds.
            a_r     <= op_a;
            b_r     <= sub ? ~op_b : op_b;
            carry_r <= sub ? 1'b1 : cin;
            sa_r    <= op_a[W-1];
            sb_r    <= sub ? ~op_b[W-1] : op_b[W-1];
            ovf_r   <= 1'b0;
            k       <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          sum_r[base +: N] <= s_chunk;
          carry_r          <= c_chunk;
          if (k == KW'(WORDS - 1)) begin
            ovf_r <= (sa_r == sb_r) && (s_chunk[N-1] != sa_r);
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_r;
  assign cout      = carry_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - scoreboard bench for the chunked rca controller
module tb_rca_seq_ctrl;

  localparam int N = 8;
  localparam int WORDS = 4;
  localparam int W = N * WORDS;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  rca_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    exp_t e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // Called #1 after a clock edge; returns the cycle number of the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sb, output int acc);
    int n;
    op_a = a; op_b = b; cin = ci; sub = sb;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    sb_q.push_back(model(a, b, ci, sb));
  endtask

  task automatic wait_out(output int t, output bit timed_out);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    timed_out = !out_valid;
    t = cyc;
  endtask

  task automatic test_reset;
    #2;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (sum !== '0) $display("FAIL reset_sum got=%h exp=0", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", cout); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic ci, input logic sb);
    int acc, t;
    bit to;
    exp_t e;
    send(a, b, ci, sb, acc);
    total++; if (busy !== 1'b1) $display("FAIL %s_busy got=%b exp=1", name, busy); else passed++;
    wait_out(t, to);
    e = sb_q.pop_front();
    total++; if (to) $display("FAIL %s_timeout got=no_out_valid exp=out_valid", name); else passed++;
    total++; if (t - acc !== WORDS) $display("FAIL %s_latency got=%0d exp=%0d", name, t - acc, WORDS); else passed++;
    total++; if (sum !== e.s) $display("FAIL %s_sum got=%h exp=%h", name, sum, e.s); else passed++;
    total++; if (cout !== e.c) $display("FAIL %s_cout got=%b exp=%b", name, cout, e.c); else passed++;
    total++; if (ovf !== e.v) $display("FAIL %s_ovf got=%b exp=%b", name, ovf, e.v); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL %s_idle got=%b exp=1", name, in_ready); else passed++;
  endtask

  task automatic test_hold;
    int acc, t;
    bit to;
    exp_t e;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, acc);
    wait_out(t, to);
    e = sb_q.pop_front();
    total++; if (to) $display("FAIL hold_timeout got=no_out_valid exp=out_valid"); else passed++;
    op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (sum !== e.s) $display("FAIL hold_sum_%0d got=%h exp=%h", i, sum, e.s); else passed++;
      total++; if (cout !== e.c) $display("FAIL hold_cout_%0d got=%b exp=%b", i, cout, e.c); else passed++;
      total++; if (ovf !== e.v) $display("FAIL hold_ovf_%0d got=%b exp=%b", i, ovf, e.v); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready_%0d got=%b exp=0", i, in_ready); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL hold_out_valid_%0d got=%b exp=1", i, out_valid); else passed++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL hold_release_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL hold_release_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL hold_release_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_reset_mid;
    int acc, t;
    bit to;
    exp_t e;
    send(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, acc);
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    total++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else passed++;
    total++; if ({sum, cout, ovf} !== '0) $display("FAIL rmid_outputs got=%h_%b_%b exp=0", sum, cout, ovf); else passed++;
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    send(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, acc);
    wait_out(t, to);
    e = sb_q.pop_front();
    total++; if (to) $display("FAIL rmid_timeout got=no_out_valid exp=out_valid"); else passed++;
    total++; if (sum !== e.s) $display("FAIL rmid_sum got=%h exp=%h", sum, e.s); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc[4];
    int got;
    out_ready = 1'b1;
    got = 0;
    fork
      begin
        send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, acc[0]);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, acc[1]);
        send(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, acc[2]);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, acc[3]);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          int t;
          bit to;
          exp_t e;
          wait_out(t, to);
          total++; if (to) $display("FAIL b2b_timeout_%0d got=no_out_valid exp=out_valid", i); else passed++;
          if (!to) begin
            e = sb_q.pop_front();
            got++;
            total++; if ({sum, cout, ovf} !== {e.s, e.c, e.v})
              $display("FAIL b2b_result_%0d got=%h_%b_%b exp=%h_%b_%b", i, sum, cout, ovf, e.s, e.c, e.v);
            else passed++;
          end
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b0;
    total++; if (got !== 4) $display("FAIL b2b_count got=%0d exp=4", got); else passed++;
    for (int i = 1; i < 4; i++) begin
      total++; if (acc[i] - acc[i-1] !== WORDS + 2)
        $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", i, acc[i] - acc[i-1], WORDS + 2);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_single("zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    test_single("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    test_single("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    test_single("sub", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    test_single("cin", 32'h00FF_00FF, 32'h0000_FF00, 1'b1, 1'b0);
    test_hold;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
